// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | counter_seq_ctrl: sequences an external up/down counter from a start value |
// | to a target, reporting step count or timeout.   Rev 1.0                    |
// +---------------------------------------------------------------------------+
module counter_seq_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_start,
  input  logic [WIDTH-1:0]   cmd_target,
  input  logic               cmd_dir,
  input  logic               abort,
  output logic               ctr_load,
  output logic [WIDTH-1:0]   ctr_data,
  output logic               ctr_up_dwn,
  input  logic [WIDTH-1:0]   ctr_out,
  output logic               done,
  output logic               err,
  output logic [WIDTH+4:0]   steps
);

  localparam int STEPS_W = WIDTH + 5;
  localparam logic [STEPS_W-1:0] TIMEOUT_LAST  = STEPS_W'(TIMEOUT - 1);
  localparam logic [STEPS_W-1:0] TIMEOUT_STEPS = STEPS_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q,      state_d;
  logic [WIDTH-1:0]     target_q,     target_d;
  logic [STEPS_W-1:0]   run_cnt_q,    run_cnt_d;
  logic                 cmd_ready_q,  cmd_ready_d;
  logic                 ctr_load_q,   ctr_load_d;
  logic [WIDTH-1:0]     ctr_data_q,   ctr_data_d;
  logic                 ctr_up_dwn_q, ctr_up_dwn_d;
  logic                 done_q,       done_d;
  logic                 err_q,        err_d;
  logic [STEPS_W-1:0]   steps_q,      steps_d;

  // All outputs are registered: each _d is the value for the state being entered.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    run_cnt_d    = run_cnt_q;
    ctr_load_d   = 1'b0;
    ctr_data_d   = ctr_data_q;
    ctr_up_dwn_d = ctr_up_dwn_q;
    done_d       = 1'b0;
    err_d        = err_q;
    steps_d      = steps_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d      = LOAD;
          ctr_data_d   = cmd_start;
          target_d     = cmd_target;
          ctr_up_dwn_d = cmd_dir;
          ctr_load_d   = 1'b1;
          run_cnt_d    = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d   = RUN;
          run_cnt_d = '0;
        end
      end
      RUN: begin
        // Abort outranks both match and timeout in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (ctr_out == target_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          steps_d = run_cnt_q;
        end else if (run_cnt_q == TIMEOUT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          steps_d = TIMEOUT_STEPS;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      target_q     <= '0;
      run_cnt_q    <= '0;
      cmd_ready_q  <= 1'b1;
      ctr_load_q   <= 1'b0;
      ctr_data_q   <= '0;
      ctr_up_dwn_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      steps_q      <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      run_cnt_q    <= run_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      ctr_load_q   <= ctr_load_d;
      ctr_data_q   <= ctr_data_d;
      ctr_up_dwn_q <= ctr_up_dwn_d;
      done_q       <= done_d;
      err_q        <= err_d;
      steps_q      <= steps_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign ctr_load   = ctr_load_q;
  assign ctr_data   = ctr_data_q;
  assign ctr_up_dwn = ctr_up_dwn_q;
  assign done       = done_q;
  assign err        = err_q;
  assign steps      = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_counter_seq_ctrl: directed bench with a behavioural counter model.      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_start = 4'd0;
  logic [3:0] cmd_target = 4'd0;
  logic       cmd_dir = 1'b1;
  logic       abort = 1'b0;
  logic       ctr_load;
  logic [3:0] ctr_data;
  logic       ctr_up_dwn;
  logic [3:0] ctr_out;
  logic       done;
  logic       err;
  logic [8:0] steps;

  logic       hold = 1'b0;
  logic [3:0] cnt;
  int         checks = 0;
  int         errors = 0;

  counter_seq_ctrl #(.WIDTH(4), .TIMEOUT(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_target (cmd_target),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .ctr_load   (ctr_load),
    .ctr_data   (ctr_data),
    .ctr_up_dwn (ctr_up_dwn),
    .ctr_out    (ctr_out),
    .done       (done),
    .err        (err),
    .steps      (steps)
  );

  always #5 clk = ~clk;

  // External counter: load has priority, otherwise count each cycle; hold pins it at 0.
  always @(posedge clk) begin
    if (!reset || hold)  cnt <= 4'd0;
    else if (ctr_load)   cnt <= ctr_data;
    else if (ctr_up_dwn) cnt <= cnt + 4'd1;
    else                 cnt <= cnt - 4'd1;
  end
  assign ctr_out = cnt;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
    check({tag, "_ctr_load"},   32'(ctr_load),   32'd0);
    check({tag, "_ctr_data"},   32'(ctr_data),   32'd0);
    check({tag, "_ctr_up_dwn"}, 32'(ctr_up_dwn), 32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_steps"},      32'(steps),      32'd0);
  endtask

  // Handshake on the next rising edge; returns just after that edge.
  task automatic issue(input string tag, input logic [3:0] s, input logic [3:0] t, input logic d);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_start  = s;
    cmd_target = t;
    cmd_dir    = d;
    check({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Latency n = done seen in the n-th cycle following the handshake edge.
  task automatic run_cmd(input string tag, input logic [3:0] s, input logic [3:0] t, input logic d,
                         input int exp_steps, input int exp_lat, input logic exp_err);
    int lat;
    lat = 0;
    issue(tag, s, t, d);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check({tag, "_load_hi"}, 32'(ctr_load),   32'd1);
        check({tag, "_data"},    32'(ctr_data),   32'(s));
        check({tag, "_dir"},     32'(ctr_up_dwn), 32'(d));
        check({tag, "_ready_lo"}, 32'(cmd_ready), 32'd0);
      end
      if (n == 2) check({tag, "_load_lo"}, 32'(ctr_load), 32'd0);
      if (done === 1'b1) lat = n;
    end
    check({tag, "_latency"}, 32'(lat),   32'(exp_lat));
    check({tag, "_steps"},   32'(steps), 32'(exp_steps));
    check({tag, "_err"},     32'(err),   32'(exp_err));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done),      32'd0);
    check({tag, "_ready_aft"}, 32'(cmd_ready), 32'd1);
    check({tag, "_err_hold"},  32'(err),       32'(exp_err));
    check({tag, "_steps_hold"}, 32'(steps),    32'(exp_steps));
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    check({tag, "_no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_rel");

    run_cmd("up_0_5",    4'd0,  4'd5,  1'b1, 5, 8, 1'b0);
    run_cmd("dn_1_14",   4'd1,  4'd14, 1'b0, 3, 6, 1'b0);
    run_cmd("eq_7",      4'd7,  4'd7,  1'b1, 0, 3, 1'b0);
    run_cmd("up_14_1",   4'd14, 4'd1,  1'b1, 3, 6, 1'b0);

    hold = 1'b1;
    run_cmd("timeout",   4'd3,  4'd9,  1'b1, 20, 22, 1'b1);
    hold = 1'b0;
    run_cmd("after_to",  4'd9,  4'd6,  1'b0, 3, 6, 1'b0);

    // Abort during RUN of 0->10 up
    issue("abort_run", 4'd0, 4'd10, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_run_ready", 32'(cmd_ready), 32'd1);
    check("abort_run_load",  32'(ctr_load),  32'd0);
    check("abort_run_steps_hold", 32'(steps), 32'd3);
    watch_no_done("abort_run", 15);
    run_cmd("post_abort", 4'd2, 4'd4, 1'b1, 2, 5, 1'b0);

    // Abort in the same cycle as a first-cycle match
    issue("abort_prio", 4'd5, 4'd5, 1'b1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    watch_no_done("abort_prio", 10);
    check("abort_prio_ready", 32'(cmd_ready), 32'd1);

    // Abort while idle is ignored
    @(negedge clk);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle_ready", 32'(cmd_ready), 32'd1);
    abort = 1'b0;
    run_cmd("post_idle_ab", 4'd8, 4'd11, 1'b1, 3, 6, 1'b0);

    // One-cycle reset during RUN
    issue("rst_run", 4'd0, 4'd12, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_run");
    watch_no_done("rst_run", 20);
    check("rst_run_ready_aft", 32'(cmd_ready), 32'd1);
    run_cmd("post_rst", 4'd3, 4'd3, 1'b0, 0, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
